// File: rtl/mem_arb_pkg.sv
// Shared FSM state encoding and requester port IDs for the memory port arbiter.
// Latency: none. This file holds only type and constant definitions.
// Backpressure: none.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_HST = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Picks the winning requester (cpu or host) from the current requests.
// Latency: purely combinational, so the result is available in the same cycle.
// Backpressure: none. Only a conflict is arbitrated, by round-robin when MEM_ARB_RR_EN is defined, else by PRIO_HOST.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit PRIO_HOST = 1'b1
) (
  input  logic cpu_req,
  input  logic hst_req,
  input  logic last_id,
  output logic any,
  output logic win_id
);

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no history, so the pointer input is intentionally ignored.
  logic unused_last_id;
  assign unused_last_id = last_id;
`endif

  // A lone requester always wins. On a conflict the configured policy decides.
  always_comb begin
    any    = cpu_req | hst_req;
    win_id = ID_CPU;
    if (cpu_req && hst_req) begin
`ifdef MEM_ARB_RR_EN
      win_id = ~last_id;
`else
      win_id = PRIO_HOST ? ID_HST : ID_CPU;
`endif
    end else if (hst_req) begin
      win_id = ID_HST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the core (cpu_*) and host (hst_*) ports, one req/ack transaction each.
// Latency: ack is visible 2 step-cycles after the grant edge. Each access takes 3 step-cycles.
// Backpressure: the losing req waits with no timeout. step=0 freezes everything. MEM_ARB_RR_EN selects round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 6,
  parameter int DW        = 16,
  parameter bit PRIO_HOST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adrs,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  input  logic          hst_req,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_adrs,
  input  logic [DW-1:0] hst_din,
  output logic          hst_ack,
  output logic [DW-1:0] hst_dout,
  output logic          mem_we,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  state_t          state, state_nxt;
  logic            a_id;
  logic            a_we;
  logic [AW-1:0]   a_adrs;
  logic [DW-1:0]   a_din;
  logic            last_id;
  logic            any;
  logic            win_id;
  logic            grant;

  arb_pick #(.PRIO_HOST(PRIO_HOST)) u_pick (
    .cpu_req (cpu_req),
    .hst_req (hst_req),
    .last_id (last_id),
    .any     (any),
    .win_id  (win_id)
  );

  assign grant = step && (state == ST_IDLE) && any;

`ifdef MEM_ARB_RR_EN
  // Remember the last winner so the other port wins the next conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= ID_CPU;
    end else if (grant) begin
      last_id <= win_id;
    end
  end
`else
  assign last_id = ID_CPU;
`endif

  // Next-state logic: IDLE waits for a request, then ACCESS and RESP follow one step each.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register. It advances only on step cycles, but reset applies on any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (step) begin
      state <= state_nxt;
    end
  end

  // Register the winner's request fields at grant, so later changes by the requester are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_id   <= ID_CPU;
      a_we   <= 1'b0;
      a_adrs <= '0;
      a_din  <= '0;
    end else if (grant) begin
      a_id   <= win_id;
      a_we   <= (win_id == ID_HST) ? hst_we   : cpu_we;
      a_adrs <= (win_id == ID_HST) ? hst_adrs : cpu_adrs;
      a_din  <= (win_id == ID_HST) ? hst_din  : cpu_din;
    end
  end

  // On leaving RESP: pulse the winner's ack and, for a read, capture the memory data into its dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ack  <= 1'b0;
      hst_ack  <= 1'b0;
      cpu_dout <= '0;
      hst_dout <= '0;
    end else if (step) begin
      cpu_ack <= (state == ST_RESP) && (a_id == ID_CPU);
      hst_ack <= (state == ST_RESP) && (a_id == ID_HST);
      if ((state == ST_RESP) && !a_we) begin
        if (a_id == ID_HST) begin
          hst_dout <= mem_dout;
        end else begin
          cpu_dout <= mem_dout;
        end
      end
    end
  end

  // Address and data hold the last granted values. Write enable is asserted only in ACCESS.
  assign mem_we   = (state == ST_ACCESS) && a_we;
  assign mem_adrs = a_adrs;
  assign mem_din  = a_din;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of directed vectors, hand-written corner sequences, and random traffic against a model.
// Latency: the model expects ack 2 step-cycles after the grant edge.
// Backpressure: requesters drop req when they see ack. The memory is step-gated with one-step read latency.
module tb_mem_port_arbiter;

  localparam bit TB_PRIO = 1'b1;

  logic        clk = 1'b0;
  logic        rst, step;
  logic        cpu_req, cpu_we, hst_req, hst_we;
  logic [5:0]  cpu_adrs, hst_adrs;
  logic [15:0] cpu_din, hst_din;
  logic        cpu_ack, hst_ack, mem_we, busy;
  logic [15:0] cpu_dout, hst_dout, mem_din, mem_dout;
  logic [5:0]  mem_adrs;

  logic        ld_en = 1'b0;
  logic [5:0]  ld_adrs;
  logic [15:0] ld_dat;
  logic [15:0] mem [64];

  int n_chk = 0;
  int n_err = 0;

  // Model state: phase 0 = free, 1 = access pending, 2 = response pending
  int          m_phase;
  logic        m_win, m_last, m_we;
  logic [5:0]  m_adrs;
  logic [15:0] m_din;
  logic        e_cack, e_hack;
  logic [15:0] e_cdout, e_hdout;
  logic [15:0] ref_mem [64];
  logic        chk_model = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(6), .DW(16), .PRIO_HOST(TB_PRIO)) dut (
    .clk(clk), .rst(rst), .step(step),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adrs(cpu_adrs), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .hst_req(hst_req), .hst_we(hst_we), .hst_adrs(hst_adrs), .hst_din(hst_din),
    .hst_ack(hst_ack), .hst_dout(hst_dout),
    .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  // Step-gated synchronous memory with a back-door load port
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_adrs] <= ld_dat;
    end else if (step) begin
      if (mem_we) mem[mem_adrs] <= mem_din;
      mem_dout <= mem[mem_adrs];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: a free port serves one request every 3 step edges
  task automatic model_edge();
    if (step && m_phase == 1 && m_we) ref_mem[m_adrs] = m_din;
    if (rst) begin
      m_phase = 0; m_last = 1'b0; m_we = 1'b0; m_adrs = '0; m_din = '0;
      e_cack = 1'b0; e_hack = 1'b0; e_cdout = '0; e_hdout = '0;
      return;
    end
    if (!step) return;
    e_cack = 1'b0;
    e_hack = 1'b0;
    if (m_phase == 0) begin
      if (cpu_req || hst_req) begin
        if (cpu_req && hst_req) begin
`ifdef MEM_ARB_RR_EN
          m_win = !m_last;
`else
          m_win = TB_PRIO;
`endif
        end else begin
          m_win = hst_req;
        end
        m_last  = m_win;
        m_we    = m_win ? hst_we   : cpu_we;
        m_adrs  = m_win ? hst_adrs : cpu_adrs;
        m_din   = m_win ? hst_din  : cpu_din;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      if (!m_we) begin
        if (m_win) e_hdout = ref_mem[m_adrs];
        else       e_cdout = ref_mem[m_adrs];
      end
      if (m_win) e_hack = 1'b1;
      else       e_cack = 1'b1;
      m_phase = 0;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    if (chk_model)
      chk("model", 64'({cpu_ack, hst_ack, busy, mem_we, mem_adrs, mem_din, cpu_dout, hst_dout}),
                   64'({e_cack, e_hack, (m_phase != 0), (m_phase == 1) && m_we, m_adrs, m_din, e_cdout, e_hdout}));
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_adrs = '0; cpu_din = '0;
    hst_req = 0; hst_we = 0; hst_adrs = '0; hst_din = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1; step = 1; cycle(); rst = 0;
  endtask

  typedef struct {
    logic rst, step, creq, cwe; logic [5:0] cadr; logic [15:0] cdin;
    logic hreq, hwe; logic [5:0] hadr; logic [15:0] hdin;
    logic cack, hack, busy, mwe; logic [5:0] madr; logic [15:0] cdout, hdout;
  } vec_t;

  vec_t tbl [12];
  vec_t v;
  int   ack_q [$];
  int   exp_n;
  int   n_rack;
  logic [15:0] w;

  initial begin
    idle_inputs();
    rst = 1; step = 1;
    // Preload memory; word 5 holds BEEF for the first read
    for (int i = 0; i < 64; i++) begin
      w = (16'(i) * 16'h0101) ^ 16'h5A00;
      if (i == 5) w = 16'hBEEF;
      ref_mem[i] = w;
      ld_en = 1; ld_adrs = 6'(i); ld_dat = w;
      cycle();
    end
    ld_en = 0;

    // Directed table: cpu read of 5, host write of 3F, cpu read back of 3F
    //           rst stp creq cwe cadr   cdin        hreq hwe hadr   hdin        ack ack bsy mwe madr   cdout      hdout
    tbl[0]  = '{1, 1,  0, 0, 6'h00, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 0, 0, 6'h00, 16'h0000, 16'h0000};
    tbl[1]  = '{0, 1,  1, 0, 6'h05, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 1, 0, 6'h05, 16'h0000, 16'h0000};
    tbl[2]  = '{0, 1,  1, 1, 6'h09, 16'hFFFF,   0, 0, 6'h00, 16'h0000,   0, 0, 1, 0, 6'h05, 16'h0000, 16'h0000};
    tbl[3]  = '{0, 1,  1, 0, 6'h05, 16'h0000,   0, 0, 6'h00, 16'h0000,   1, 0, 0, 0, 6'h05, 16'hBEEF, 16'h0000};
    tbl[4]  = '{0, 1,  0, 0, 6'h00, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 0, 0, 6'h05, 16'hBEEF, 16'h0000};
    tbl[5]  = '{0, 1,  0, 0, 6'h00, 16'h0000,   1, 1, 6'h3F, 16'h1234,   0, 0, 1, 1, 6'h3F, 16'hBEEF, 16'h0000};
    tbl[6]  = '{0, 1,  0, 0, 6'h00, 16'h0000,   1, 1, 6'h3F, 16'h1234,   0, 0, 1, 0, 6'h3F, 16'hBEEF, 16'h0000};
    tbl[7]  = '{0, 1,  0, 0, 6'h00, 16'h0000,   1, 1, 6'h3F, 16'h1234,   0, 1, 0, 0, 6'h3F, 16'hBEEF, 16'h0000};
    tbl[8]  = '{0, 1,  1, 0, 6'h3F, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 1, 0, 6'h3F, 16'hBEEF, 16'h0000};
    tbl[9]  = '{0, 1,  1, 0, 6'h3F, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 1, 0, 6'h3F, 16'hBEEF, 16'h0000};
    tbl[10] = '{0, 1,  1, 0, 6'h3F, 16'h0000,   0, 0, 6'h00, 16'h0000,   1, 0, 0, 0, 6'h3F, 16'h1234, 16'h0000};
    tbl[11] = '{0, 1,  0, 0, 6'h00, 16'h0000,   0, 0, 6'h00, 16'h0000,   0, 0, 0, 0, 6'h3F, 16'h1234, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      rst = v.rst; step = v.step;
      cpu_req = v.creq; cpu_we = v.cwe; cpu_adrs = v.cadr; cpu_din = v.cdin;
      hst_req = v.hreq; hst_we = v.hwe; hst_adrs = v.hadr; hst_din = v.hdin;
      cycle();
      chk($sformatf("vec%0d", i),
          64'({cpu_ack, hst_ack, busy, mem_we, mem_adrs, cpu_dout, hst_dout}),
          64'({v.cack, v.hack, v.busy, v.mwe, v.madr, v.cdout, v.hdout}));
    end

    // Both requesters held high from reset: the sequence of ack owners
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_n = 6;
`else
    exp_n = 4;
`endif
    cpu_req = 1; cpu_adrs = 6'h01; hst_req = 1; hst_adrs = 6'h02;
    ack_q.delete();
    for (int c = 0; c < exp_n * 3; c++) begin
      cycle();
      if (cpu_ack) ack_q.push_back(0);
      if (hst_ack) ack_q.push_back(1);
    end
    chk("both_count", 64'(ack_q.size()), 64'(exp_n));
    for (int k = 0; k < exp_n; k++) begin
`ifdef MEM_ARB_RR_EN
      chk($sformatf("both_owner%0d", k), 64'((k < ack_q.size()) ? ack_q[k] : -1), 64'((k % 2 == 0) ? 1 : 0));
`else
      chk($sformatf("both_owner%0d", k), 64'((k < ack_q.size()) ? ack_q[k] : -1), 64'(TB_PRIO));
`endif
    end

    // step freeze during a cpu read
    do_reset();
    cpu_req = 1; cpu_adrs = 6'h05; step = 1; cycle();
    chk("frz_grant", 64'(busy), 64'(1));
    step = 0; cycle();
    chk("frz_hold1", 64'({busy, cpu_ack, mem_adrs}), 64'({1'b1, 1'b0, 6'h05}));
    step = 0; cycle();
    chk("frz_hold2", 64'({busy, cpu_ack, mem_adrs}), 64'({1'b1, 1'b0, 6'h05}));
    step = 1; cycle();
    chk("frz_resp", 64'({busy, cpu_ack}), 64'(2'b10));
    step = 1; cycle();
    chk("frz_ack", 64'({cpu_ack, hst_ack, cpu_dout}), 64'({1'b1, 1'b0, 16'hBEEF}));
    cpu_req = 0; step = 0; cycle();
    chk("frz_ack_held", 64'(cpu_ack), 64'(1));
    step = 1; cycle();
    chk("frz_ack_clr", 64'({cpu_ack, busy}), 64'(0));
    cycle();
    chk("frz_no_regrant", 64'({cpu_ack, busy}), 64'(0));

    // Reset while a write is in ACCESS
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_adrs = 6'h10; cpu_din = 16'hAAAA; cycle();
    chk("rst_access", 64'({busy, mem_we, mem_adrs}), 64'({1'b1, 1'b1, 6'h10}));
    rst = 1; cpu_req = 0; cycle();
    chk("rst_abort", 64'({busy, cpu_ack, hst_ack, mem_we}), 64'(0));
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk($sformatf("rst_quiet%0d", c), 64'({busy, cpu_ack, hst_ack, mem_we}), 64'(0));
    end

    // Random traffic against the model
    chk_model = 1'b1;
    n_rack = 0;
    for (int c = 0; c < 800; c++) begin
      if (cpu_ack) begin
        if (cpu_req) n_rack++;
        cpu_req = 0;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_adrs = 6'($urandom_range(8, 23)); cpu_din = 16'($urandom);
      end
      if (hst_ack) begin
        if (hst_req) n_rack++;
        hst_req = 0;
      end else if (!hst_req && $urandom_range(0, 2) == 0) begin
        hst_req = 1; hst_we = 1'($urandom_range(0, 1));
        hst_adrs = 6'($urandom_range(8, 23)); hst_din = 16'($urandom);
      end
      step = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 199) == 0);
      cycle();
    end
    chk_model = 1'b0;
    chk("rand_progress", 64'(n_rack > 50), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
